// File: rtl/brick_ram_ctrl.sv
// Brick-wall state RAM with refill/video/hit arbitration, one access per clock.
// Optional BRICK_COUNT_EN adds a remaining-brick counter and wall-cleared pulse.
module brick_ram_ctrl #(
   parameter int ROWS = 8,
   parameter int COLS = 16,
   parameter int AW   = 7
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_new_wall,
   input  logic          i_vid_req,
   input  logic [AW-1:0] i_vid_addr,
   output logic          o_brick_display,
   input  logic          i_hit_req,
   input  logic [AW-1:0] i_hit_addr,
   output logic          o_hit_ack,
   output logic          o_hit_was_brick,
   output logic          o_busy
`ifdef BRICK_COUNT_EN
   ,
   output logic [AW:0]   o_bricks_left,
   output logic          o_wall_cleared
`endif
);

   localparam int          CELLS_I = ROWS * COLS;
   localparam logic [AW:0] CELLS   = (AW+1)'(CELLS_I);
   localparam logic [AW:0] LAST    = CELLS - 1'b1;

   typedef enum logic [1:0] {
      FILL,
      RUN,
      HIT_WR
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CELLS_I-1:0]   r_mem;
   logic [AW:0]          r_ptr;
   logic                 r_disp;
   logic                 r_ack;
   logic                 r_was;
   logic                 r_hit_bit;

   logic                 w_vid_gnt;
   logic                 w_hit_gnt;
   logic                 w_hit_done;
   logic                 w_fill_wr;
   logic                 w_refill;
   logic                 w_vid_ok;
   logic                 w_hit_ok;
   logic                 w_vid_bit;
   logic                 w_hit_bit;

   assign w_vid_ok  = {1'b0, i_vid_addr} < CELLS;
   assign w_hit_ok  = {1'b0, i_hit_addr} < CELLS;
   assign w_vid_bit = w_vid_ok & r_mem[i_vid_addr];
   assign w_hit_bit = w_hit_ok & r_mem[i_hit_addr];

   // A request still high during its own ack cycle is not re-granted.
   always_comb begin
      w_state_nxt = r_state;
      w_vid_gnt   = 1'b0;
      w_hit_gnt   = 1'b0;
      w_hit_done  = 1'b0;
      w_fill_wr   = 1'b0;
      w_refill    = 1'b0;
      if (i_new_wall) begin
         w_refill    = 1'b1;
         w_state_nxt = FILL;
      end else begin
         unique case (r_state)
            FILL: begin
               w_fill_wr = 1'b1;
               if (r_ptr == LAST) w_state_nxt = RUN;
            end
            RUN: begin
               if (i_vid_req) begin
                  w_vid_gnt = 1'b1;
               end else if (i_hit_req && !r_ack) begin
                  w_hit_gnt   = 1'b1;
                  w_state_nxt = HIT_WR;
               end
            end
            HIT_WR: begin
               if (i_vid_req) begin
                  w_vid_gnt = 1'b1;
               end else begin
                  w_hit_done  = 1'b1;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= FILL;
         r_mem     <= '0;
         r_ptr     <= '0;
         r_disp    <= 1'b0;
         r_ack     <= 1'b0;
         r_was     <= 1'b0;
         r_hit_bit <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_hit_done;
         r_was   <= w_hit_done & r_hit_bit;
         if (w_refill) begin
            r_ptr <= '0;
         end else if (w_fill_wr) begin
            r_mem[r_ptr[AW-1:0]] <= 1'b1;
            r_ptr                <= r_ptr + 1'b1;
         end
         if (w_refill || r_state == FILL) begin
            r_disp <= 1'b0;
         end else if (w_vid_gnt) begin
            r_disp <= w_vid_bit;
         end
         if (w_hit_gnt) r_hit_bit <= w_hit_bit;
         if (w_hit_done && w_hit_ok) r_mem[i_hit_addr] <= 1'b0;
      end
   end

   assign o_brick_display = r_disp;
   assign o_hit_ack       = r_ack;
   assign o_hit_was_brick = r_was;
   assign o_busy          = (r_state == FILL);

`ifdef BRICK_COUNT_EN
   logic [AW:0] r_left;
   logic        r_clr;

   // Count moves on the same edge that raises the ack it accounts for.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_left <= '0;
         r_clr  <= 1'b0;
      end else begin
         r_clr <= 1'b0;
         if (w_refill) begin
            r_left <= '0;
         end else if (r_state == FILL) begin
            r_left <= (w_state_nxt == RUN) ? CELLS : '0;
         end else if (w_hit_done && r_hit_bit && r_left != '0) begin
            r_left <= r_left - 1'b1;
            r_clr  <= (r_left == (AW+1)'(1));
         end
      end
   end

   assign o_bricks_left  = r_left;
   assign o_wall_cleared = r_clr;
`endif

endmodule

// File: doc/brick_ram_ctrl.md
Name: brick_ram_ctrl

Overview:
- Owns the brick-wall state memory: ROWS x COLS bits, one bit per brick, 1 = brick present.
- Arbitrates one access per cycle among three users: the wall-refill sequencer, the video brick fetch, and ball-collision hit/erase requests.
- Drives BRICK_DISPLAY into the playfield combiner and reports hit results to the ball/score logic.
- Models a single-port RAM, so exactly one access is granted per CLK.

Parameters:
- ROWS, 8, number of brick rows.
- COLS, 16, bricks per row.
- AW, 7, address width; must equal log2(ROWS*COLS); address = row*COLS + col.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- NEW_WALL  in  1  one-cycle pulse: refill the entire wall.
- VID_REQ  in  1  video fetch strobe, at most one per 8 H-pixels.
- VID_ADDR  in  AW  brick address for the video fetch.
- BRICK_DISPLAY  out  1  registered brick bit for the current video cell.
- HIT_REQ  in  1  collision request; level, held until HIT_ACK.
- HIT_ADDR  in  AW  brick under the ball; stable while HIT_REQ is high.
- HIT_ACK  out  1  one-cycle completion pulse.
- HIT_WAS_BRICK  out  1  valid with HIT_ACK; 1 = a brick was present and has been erased.
- BUSY  out  1  high while the wall refill is in progress.

Behaviour:
- Reset (async): memory cleared to all 0; state = FILL with fill pointer 0; BRICK_DISPLAY=0, HIT_ACK=0, HIT_WAS_BRICK=0, BUSY=1.
- The wall is therefore refilled automatically after reset is released.
- State machine: FILL, RUN, HIT_WR.
- FILL:
  - Each cycle writes 1 to cell[ptr], then ptr increments.
  - After writing cell ROWS*COLS-1, the next state is RUN; BUSY is low from that RUN cycle onward.
  - Video and hit requests are not granted during FILL: BRICK_DISPLAY is forced to 0 and HIT_REQ waits.
  - Total fill time is ROWS*COLS cycles.
- RUN, arbitration priority per cycle is NEW_WALL > VID_REQ > HIT_REQ.
  - NEW_WALL: ptr:=0, go to FILL.
  - VID_REQ: read cell[VID_ADDR]; BRICK_DISPLAY updates on the next edge (latency 1) and holds until the next granted VID_REQ.
  - HIT_REQ granted (no VID_REQ this cycle): read cell[HIT_ADDR] into a latch, go to HIT_WR.
- HIT_WR:
  - If VID_REQ is high, the video read is granted and the state stays in HIT_WR, so the hit is stalled.
  - Otherwise: clear cell[HIT_ADDR] (a no-op write if already 0); pulse HIT_ACK for one cycle with HIT_WAS_BRICK equal to the latched bit; return to RUN.
  - Total hit latency is 2 cycles when uncontended.
- NEW_WALL during HIT_WR: FILL wins. The pending hit is dropped without an ack. The requester keeps HIT_REQ high and is served after the fill.
- HIT_ACK registered low in the cycle after the pulse. HIT_REQ is expected low by then; a re-asserted HIT_REQ is treated as a new request.
- NEW_WALL during FILL restarts ptr at 0.
- HIT_ADDR or VID_ADDR >= ROWS*COLS: the read returns 0 and the write is suppressed.
- Fill pointer width is AW+1 so the terminal count does not alias.

Optional Feature:
- Macro: BRICK_COUNT_EN.
- When defined, two outputs are added:
  - BRICKS_LEFT (AW+1 bits): loaded with ROWS*COLS at the end of FILL, 0 during FILL and after reset. Decremented on every HIT_ACK with HIT_WAS_BRICK=1; never wraps below 0.
  - WALL_CLEARED (1 bit): one-cycle pulse on the cycle BRICKS_LEFT transitions 1->0.
- When undefined, neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Release RESET, wait 128 cycles -> BUSY falls at cycle 128. A VID_REQ at addr 0 and one at addr 127 each give BRICK_DISPLAY=1 one cycle later.
- HIT_REQ on addr 37 in RUN with no video -> HIT_ACK at cycle 2 with HIT_WAS_BRICK=1. A following VID_REQ at 37 gives BRICK_DISPLAY=0. A second hit on 37 gives HIT_WAS_BRICK=0.
- VID_REQ held high 3 cycles while HIT_REQ(5) pending -> the ack is delayed exactly 3 cycles, and video data stays correct each cycle.
- NEW_WALL asserted in the HIT_WR cycle of a hit on 9 -> no HIT_ACK, BUSY for 128 cycles. The hit then completes with HIT_WAS_BRICK=1 and cell 9 is 0.
- Assert RESET asynchronously mid-FILL (ptr=60) -> outputs zero immediately; after release a full 128-cycle fill completes.
- BRICK_COUNT_EN: erase all 128 bricks -> BRICKS_LEFT steps 128..0, WALL_CLEARED pulses once. A duplicate hit at 0 leaves the count at 0.
